// File: rtl/vend_pkg.sv
// Shared types and defaults for the vending controller.
package vend_pkg;

    localparam int CREDIT_W = 8;

    localparam logic [CREDIT_W-1:0] PRICE_G1_DEF    = 8'd5;
    localparam logic [CREDIT_W-1:0] PRICE_G2_DEF    = 8'd10;
    localparam int                  DISP_CYCLES_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READY    = 3'd1,
        ST_DEBIT    = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_DISPENSE = 3'd4,
        ST_CHANGE   = 3'd5
    } state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CREDIT_W-1:0] sat_inc(input logic [CREDIT_W-1:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector for a level button; stays quiet for the first
// cycle after reset so a button already held does not look like a press.
module edge_rise (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic prev_r;
    logic armed_r;

    // Capture the previous level and arm once a real sample has been taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_r  <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            prev_r  <= level;
            armed_r <= 1'b1;
        end
    end

    assign rise = armed_r & level & ~prev_r;

endmodule

// File: rtl/vend_controller.sv
// Vending session controller: selection, debit, timed dispense and change
// return against the credit reported by the coin collector.
module vend_controller
    import vend_pkg::*;
#(
    parameter logic [CREDIT_W-1:0] PRICE_G1    = PRICE_G1_DEF,
    parameter logic [CREDIT_W-1:0] PRICE_G2    = PRICE_G2_DEF,
    parameter int                  DISP_CYCLES = DISP_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CREDIT_W-1:0] amount_value,
    input  logic                op_start,
    input  logic                sel_g1,
    input  logic                sel_g2,
    input  logic                done_btn,
    output logic                g1_bought,
    output logic                g2_bought,
    output logic                dispense_g1,
    output logic                dispense_g2,
    output logic                cancel_req,
    output logic [CREDIT_W-1:0] change_amt,
    output logic                change_valid,
    output logic                err_insufficient,
    output logic                busy,
    output logic [CREDIT_W-1:0] vend_count
);

    localparam logic [7:0] DISP_LAST = 8'(DISP_CYCLES - 1);

    state_t     state_r;
    logic       good_r;       // 0 selects good 1, 1 selects good 2
    logic       pending_r;
    logic [7:0] cnt_r;
    logic       sel1_s;
    logic       sel2_s;
    logic       done_s;
    logic       pending_s;

    edge_rise u_edge_g1   (.clk(clk), .rst(rst), .level(sel_g1),   .rise(sel1_s));
    edge_rise u_edge_g2   (.clk(clk), .rst(rst), .level(sel_g2),   .rise(sel2_s));
    edge_rise u_edge_done (.clk(clk), .rst(rst), .level(done_btn), .rise(done_s));

    assign pending_s = pending_r | done_s;

    // Session FSM with all outputs registered; strobes default low each cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r          <= ST_IDLE;
            good_r           <= 1'b0;
            pending_r        <= 1'b0;
            cnt_r            <= 8'd0;
            g1_bought        <= 1'b0;
            g2_bought        <= 1'b0;
            dispense_g1      <= 1'b0;
            dispense_g2      <= 1'b0;
            cancel_req       <= 1'b0;
            change_amt       <= 8'd0;
            change_valid     <= 1'b0;
            err_insufficient <= 1'b0;
            busy             <= 1'b0;
            vend_count       <= 8'd0;
        end else begin
            g1_bought        <= 1'b0;
            g2_bought        <= 1'b0;
            cancel_req       <= 1'b0;
            change_amt       <= 8'd0;
            change_valid     <= 1'b0;
            err_insufficient <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (op_start && (amount_value != 8'd0)) begin
                        state_r <= ST_READY;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                    busy <= 1'b0;
                end
                ST_READY: begin
                    if (done_s) begin
                        state_r      <= ST_CHANGE;
                        busy         <= 1'b1;
                        change_valid <= 1'b1;
                        change_amt   <= amount_value;
                        cancel_req   <= 1'b1;
                    end else if (sel1_s && sel2_s) begin
                        state_r <= ST_READY;
                    end else if (sel1_s) begin
                        if (amount_value >= PRICE_G1) begin
                            state_r   <= ST_DEBIT;
                            good_r    <= 1'b0;
                            g1_bought <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            err_insufficient <= 1'b1;
                        end
                    end else if (sel2_s) begin
                        if (amount_value >= PRICE_G2) begin
                            state_r   <= ST_DEBIT;
                            good_r    <= 1'b1;
                            g2_bought <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            err_insufficient <= 1'b1;
                        end
                    end else if (!op_start) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_READY;
                    end
                end
                ST_DEBIT: begin
                    state_r   <= ST_SETTLE;
                    pending_r <= pending_s;
                end
                ST_SETTLE: begin
                    state_r     <= ST_DISPENSE;
                    pending_r   <= pending_s;
                    cnt_r       <= 8'd0;
                    dispense_g1 <= ~good_r;
                    dispense_g2 <= good_r;
                end
                ST_DISPENSE: begin
                    pending_r <= pending_s;
                    if (cnt_r == DISP_LAST) begin
                        dispense_g1 <= 1'b0;
                        dispense_g2 <= 1'b0;
                        vend_count  <= sat_inc(vend_count);
                        if (pending_s) begin
                            state_r      <= ST_CHANGE;
                            change_valid <= 1'b1;
                            change_amt   <= amount_value;
                            cancel_req   <= 1'b1;
                        end else if (!op_start || (amount_value == 8'd0)) begin
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            state_r <= ST_READY;
                            busy    <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_CHANGE: begin
                    state_r   <= ST_IDLE;
                    pending_r <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    pending_r   <= 1'b0;
                    dispense_g1 <= 1'b0;
                    dispense_g2 <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller with default prices and dispense length.
module tb_vend_controller;

    logic       clk;
    logic       rst;
    logic [7:0] amount_value;
    logic       op_start;
    logic       sel_g1;
    logic       sel_g2;
    logic       done_btn;
    logic       g1_bought;
    logic       g2_bought;
    logic       dispense_g1;
    logic       dispense_g2;
    logic       cancel_req;
    logic [7:0] change_amt;
    logic       change_valid;
    logic       err_insufficient;
    logic       busy;
    logic [7:0] vend_count;

    int checks;
    int failures;

    vend_controller dut (
        .clk(clk), .rst(rst), .amount_value(amount_value), .op_start(op_start),
        .sel_g1(sel_g1), .sel_g2(sel_g2), .done_btn(done_btn),
        .g1_bought(g1_bought), .g2_bought(g2_bought),
        .dispense_g1(dispense_g1), .dispense_g2(dispense_g2),
        .cancel_req(cancel_req), .change_amt(change_amt), .change_valid(change_valid),
        .err_insufficient(err_insufficient), .busy(busy), .vend_count(vend_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0; amount_value = 8'd0; op_start = 1'b0;
        sel_g1 = 1'b0; sel_g2 = 1'b0; done_btn = 1'b0;
        tick; tick;
        checks++;
        if ({g1_bought, g2_bought, dispense_g1, dispense_g2, cancel_req, change_valid,
             err_insufficient, busy} !== 8'h00) begin
            failures++; $display("FAIL reset_strobes: got %b want 00000000",
                {g1_bought, g2_bought, dispense_g1, dispense_g2, cancel_req, change_valid,
                 err_insufficient, busy});
        end
        checks++;
        if (vend_count !== 8'd0 || change_amt !== 8'd0) begin
            failures++; $display("FAIL reset_counts: vend_count=%0d change_amt=%0d want 0/0",
                vend_count, change_amt);
        end
        rst = 1'b1;
        tick;
    endtask

    task automatic test_vend_g1;
        amount_value = 8'd20; op_start = 1'b1;
        tick;
        sel_g1 = 1'b1;
        tick;
        checks++;
        if (g1_bought !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL vend_debit: g1_bought=%b busy=%b want 1/1", g1_bought, busy);
        end
        tick;
        checks++;
        if (g1_bought !== 1'b0 || dispense_g1 !== 1'b0) begin
            failures++; $display("FAIL vend_settle: g1_bought=%b dispense_g1=%b want 0/0",
                g1_bought, dispense_g1);
        end
        tick;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dispense_g1 !== 1'b1 || dispense_g2 !== 1'b0) begin
                failures++; $display("FAIL vend_dispense_%0d: g1=%b g2=%b want 1/0",
                    i, dispense_g1, dispense_g2);
            end
            tick;
        end
        checks++;
        if (dispense_g1 !== 1'b0 || vend_count !== 8'd1 || busy !== 1'b0) begin
            failures++; $display("FAIL vend_end: disp=%b count=%0d busy=%b want 0/1/0",
                dispense_g1, vend_count, busy);
        end
        sel_g1 = 1'b0;
        tick;
    endtask

    task automatic test_insufficient;
        amount_value = 8'd2;
        sel_g2 = 1'b1;
        tick;
        checks++;
        if (err_insufficient !== 1'b1 || g2_bought !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL insuff_pulse: err=%b g2_bought=%b busy=%b want 1/0/0",
                err_insufficient, g2_bought, busy);
        end
        tick;
        checks++;
        if (err_insufficient !== 1'b0) begin
            failures++; $display("FAIL insuff_single: err=%b want 0", err_insufficient);
        end
        sel_g2 = 1'b0;
        tick;
    endtask

    task automatic test_done_ready;
        amount_value = 8'd15;
        done_btn = 1'b1;
        tick;
        checks++;
        if (change_valid !== 1'b1 || change_amt !== 8'd15 || cancel_req !== 1'b1) begin
            failures++; $display("FAIL done_change: valid=%b amt=%0d cancel=%b want 1/15/1",
                change_valid, change_amt, cancel_req);
        end
        op_start = 1'b0; done_btn = 1'b0;
        tick;
        checks++;
        if (change_valid !== 1'b0 || change_amt !== 8'd0 || cancel_req !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL done_after: valid=%b amt=%0d cancel=%b busy=%b want 0/0/0/0",
                change_valid, change_amt, cancel_req, busy);
        end
        sel_g1 = 1'b1;
        tick;
        checks++;
        if (g1_bought !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL idle_ignores_sel: g1_bought=%b busy=%b want 0/0",
                g1_bought, busy);
        end
        sel_g1 = 1'b0;
        tick;
    endtask

    task automatic test_done_during_dispense;
        amount_value = 8'd10; op_start = 1'b1;
        tick;
        sel_g1 = 1'b1;
        tick;
        checks++;
        if (g1_bought !== 1'b1) begin
            failures++; $display("FAIL dd_debit: g1_bought=%b want 1", g1_bought);
        end
        sel_g1 = 1'b0;
        tick; tick;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dispense_g1 !== 1'b1) begin
                failures++; $display("FAIL dd_dispense_%0d: dispense_g1=%b want 1", i, dispense_g1);
            end
            if (i == 1) done_btn = 1'b1;
            if (i == 2) done_btn = 1'b0;
            tick;
        end
        checks++;
        if (change_valid !== 1'b1 || change_amt !== 8'd10 || cancel_req !== 1'b1 ||
            dispense_g1 !== 1'b0 || vend_count !== 8'd2) begin
            failures++; $display("FAIL dd_change: valid=%b amt=%0d cancel=%b disp=%b count=%0d want 1/10/1/0/2",
                change_valid, change_amt, cancel_req, dispense_g1, vend_count);
        end
        tick;
        checks++;
        if (change_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL dd_idle: valid=%b busy=%b want 0/0", change_valid, busy);
        end
    endtask

    task automatic test_held_and_simultaneous;
        int n_buy;
        int n_disp;
        int n_strobe;
        amount_value = 8'd30;
        tick;
        sel_g1 = 1'b1;
        n_buy = 0; n_disp = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (g1_bought === 1'b1) n_buy++;
            if (dispense_g1 === 1'b1) n_disp++;
        end
        checks++;
        if (n_buy !== 1 || n_disp !== 4 || vend_count !== 8'd3 || busy !== 1'b0) begin
            failures++; $display("FAIL held_once: buys=%0d disp=%0d count=%0d busy=%b want 1/4/3/0",
                n_buy, n_disp, vend_count, busy);
        end
        sel_g1 = 1'b0;
        tick;
        sel_g1 = 1'b1; sel_g2 = 1'b1;
        n_strobe = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (g1_bought === 1'b1 || g2_bought === 1'b1 || err_insufficient === 1'b1 ||
                busy === 1'b1) n_strobe++;
        end
        checks++;
        if (n_strobe !== 0) begin
            failures++; $display("FAIL simultaneous: strobe_cycles=%0d want 0", n_strobe);
        end
        sel_g1 = 1'b0; sel_g2 = 1'b0;
        tick;
    endtask

    task automatic test_price_boundary;
        amount_value = 8'd4;
        sel_g1 = 1'b1;
        tick;
        checks++;
        if (err_insufficient !== 1'b1 || g1_bought !== 1'b0) begin
            failures++; $display("FAIL below_price: err=%b g1_bought=%b want 1/0",
                err_insufficient, g1_bought);
        end
        sel_g1 = 1'b0;
        tick;
        amount_value = 8'd5;
        sel_g1 = 1'b1;
        tick;
        checks++;
        if (g1_bought !== 1'b1 || err_insufficient !== 1'b0) begin
            failures++; $display("FAIL at_price: g1_bought=%b err=%b want 1/0",
                g1_bought, err_insufficient);
        end
        sel_g1 = 1'b0;
        for (int i = 0; i < 6; i++) tick;
        checks++;
        if (vend_count !== 8'd4 || dispense_g1 !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL at_price_done: count=%0d disp=%b busy=%b want 4/0/0",
                vend_count, dispense_g1, busy);
        end
    endtask

    task automatic test_reset_mid_dispense;
        int n_buy;
        amount_value = 8'd30;
        sel_g1 = 1'b1;
        tick; tick; tick; tick;
        checks++;
        if (dispense_g1 !== 1'b1) begin
            failures++; $display("FAIL rst_pre: dispense_g1=%b want 1", dispense_g1);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (dispense_g1 !== 1'b0 || vend_count !== 8'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL rst_async: disp=%b count=%0d busy=%b want 0/0/0",
                dispense_g1, vend_count, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        tick;
        checks++;
        if (busy !== 1'b0 || g1_bought !== 1'b0) begin
            failures++; $display("FAIL rst_release: busy=%b g1_bought=%b want 0/0", busy, g1_bought);
        end
        n_buy = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (g1_bought === 1'b1 || busy === 1'b1) n_buy++;
        end
        checks++;
        if (n_buy !== 0 || vend_count !== 8'd0) begin
            failures++; $display("FAIL held_after_reset: active_cycles=%0d count=%0d want 0/0",
                n_buy, vend_count);
        end
        sel_g1 = 1'b0;
        tick;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset;
        test_vend_g1;
        test_insufficient;
        test_done_ready;
        test_done_during_dispense;
        test_held_and_simultaneous;
        test_price_boundary;
        test_reset_mid_dispense;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
